// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and dispatch: DEPTH-entry circular FIFO of
// {instr, pc, predicted next pc} with first-word-fall-through head and flush.
module fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WORD_W-1:0]          in_instr,
  input  logic [WORD_W-1:0]          in_pc,
  input  logic [WORD_W-1:0]          in_pred,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WORD_W-1:0]          out_instr,
  output logic [WORD_W-1:0]          out_pc,
  output logic [WORD_W-1:0]          out_pred,
  input  logic                       dispatch_free,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [3*WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic                push;
  logic                pop;

  // in_ready depends on count alone, so a same-cycle pop never frees a slot
  // for a same-cycle push and dispatch_free never reaches the fetch stall.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && dispatch_free;

  assign {out_instr, out_pc, out_pred} = mem[head];

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge CLK) begin
    if (!RST && !flush && push)
      mem[tail] <= {in_instr, in_pc, in_pred};
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed plan plus random traffic
// compared every cycle against a queue-based model of the FIFO.
module tb_fetch_buffer;

  localparam int DEPTH  = 4;
  localparam int WORD_W = 32;

  logic              CLK;
  logic              RST;
  logic              flush;
  logic              in_valid;
  logic [WORD_W-1:0] in_instr;
  logic [WORD_W-1:0] in_pc;
  logic [WORD_W-1:0] in_pred;
  logic              in_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_instr;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_pred;
  logic              dispatch_free;
  logic [2:0]        count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pred;
  } entry_t;

  entry_t model_q[$];
  bit     model_ready = 0;

  fetch_buffer #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .flush(flush),
    .in_valid(in_valid),
    .in_instr(in_instr),
    .in_pc(in_pc),
    .in_pred(in_pred),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_pred(out_pred),
    .dispatch_free(dispatch_free),
    .count(count)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return shortly after the capturing edge.
  task automatic applyStimulus(input bit rst, input bit fl, input bit v,
                               input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] pred, input bit df);
    RST = rst; flush = fl; in_valid = v;
    in_instr = instr; in_pc = pc; in_pred = pred; dispatch_free = df;
    @(posedge CLK);
    #2;
  endtask

  // Reference: a plain queue; accept when not full, dispatch when non-empty.
  always @(posedge CLK) begin
    bit do_push, do_pop;
    if (RST || flush) begin
      model_q.delete();
      if (RST) model_ready = 1;
    end else if (model_ready) begin
      do_push = in_valid && (model_q.size() < DEPTH);
      do_pop  = dispatch_free && (model_q.size() > 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back('{instr: in_instr, pc: in_pc, pred: in_pred});
    end
  end

  always @(negedge CLK) begin
    if (model_ready) begin
      checkOutput("cyc_count", {29'b0, count}, 32'(model_q.size()));
      checkOutput("cyc_in_ready", {31'b0, in_ready}, {31'b0, model_q.size() != DEPTH});
      checkOutput("cyc_out_valid", {31'b0, out_valid}, {31'b0, model_q.size() != 0});
      if (model_q.size() != 0) begin
        checkOutput("cyc_out_instr", out_instr, model_q[0].instr);
        checkOutput("cyc_out_pc", out_pc, model_q[0].pc);
        checkOutput("cyc_out_pred", out_pred, model_q[0].pred);
      end
    end
  end

  initial begin
    logic [31:0] pc;

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("reset_count", {29'b0, count}, 32'd0);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      pc = 32'h100 + 32'(4 * i);
      applyStimulus(0, 0, 1, 32'h00000013, pc, pc + 32'd4, 0);
    end
    checkOutput("fill_count", {29'b0, count}, 32'd4);
    checkOutput("fill_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("fill_out_pc", out_pc, 32'h100);
    applyStimulus(0, 0, 1, 32'h00000013, 32'h110, 32'h114, 0);
    checkOutput("full_reject_count", {29'b0, count}, 32'd4);
    checkOutput("full_reject_out_pc", out_pc, 32'h100);

    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_out_pc", out_pc, 32'h100 + 32'(4 * i));
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
    end
    checkOutput("drain_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("drain_count", {29'b0, count}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      pc = 32'h200 + 32'(4 * i);
      applyStimulus(0, 0, 1, 32'h00000013, pc, pc + 32'd4, 1);
      checkOutput("stream_count", {29'b0, count}, 32'd1);
      checkOutput("stream_out_pc", out_pc, pc);
    end

    for (int i = 0; i < 3; i++) begin
      pc = 32'h230 + 32'(4 * i);
      applyStimulus(0, 0, 1, 32'h00000013, pc, pc + 32'd4, 0);
    end
    checkOutput("refill_count", {29'b0, count}, 32'd4);
    checkOutput("refill_out_pc", out_pc, 32'h224);
    applyStimulus(0, 0, 1, 32'h00000013, 32'h300, 32'h304, 1);
    checkOutput("fullpop_count", {29'b0, count}, 32'd3);
    checkOutput("fullpop_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("fullpop_out_pc", out_pc, 32'h230);

    applyStimulus(0, 1, 1, 32'h00000013, 32'h310, 32'h314, 1);
    checkOutput("flush_count", {29'b0, count}, 32'd0);
    checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
    applyStimulus(0, 0, 1, 32'h00000013, 32'h400, 32'h404, 0);
    checkOutput("postflush_out_pc", out_pc, 32'h400);
    checkOutput("postflush_count", {29'b0, count}, 32'd1);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
                    $urandom_range(0, 2) != 0, $urandom, $urandom, $urandom,
                    $urandom_range(0, 2) == 0 || (i > 1500 && $urandom_range(0, 1) == 1));
    end

    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
